// File: rtl/alu_flag_unit.sv
// ALU flag register with Z accumulation across compare chains, plus a
// ready/valid/ack conditional-jump evaluator. Optional macro: FLAG_SHADOW_EN.
module alu_flag_unit #(
  parameter int WIDTH     = 8,
  parameter int NUM_CONDS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             aluout,
  input  logic                         carryout,
  input  logic                         overout,
  input  logic                         cmpo,
  input  logic                         cmp_chain,
  input  logic                         clr_flags,
  input  logic                         signed_in,
  input  logic                         jmp_req,
  input  logic [$clog2(NUM_CONDS)-1:0] cond,
  input  logic                         jmp_ack,
`ifdef FLAG_SHADOW_EN
  input  logic                         save_flags,
  input  logic                         restore_flags,
  output logic [3:0]                   shadow,
`endif
  output logic                         jmp_ready,
  output logic                         jmp_valid,
  output logic                         jmp_taken,
  output logic [3:0]                   flags
);

  localparam int CW = $clog2(NUM_CONDS);

  localparam logic [CW-1:0] C_ALWAYS = CW'(0);
  localparam logic [CW-1:0] C_Z      = CW'(1);
  localparam logic [CW-1:0] C_NZ     = CW'(2);
  localparam logic [CW-1:0] C_C      = CW'(3);
  localparam logic [CW-1:0] C_NC     = CW'(4);
  localparam logic [CW-1:0] C_N      = CW'(5);
  localparam logic [CW-1:0] C_NN     = CW'(6);
  localparam logic [CW-1:0] C_O      = CW'(7);
  localparam logic [CW-1:0] C_NO     = CW'(8);
  localparam logic [CW-1:0] C_LT     = CW'(9);
  localparam logic [CW-1:0] C_GE     = CW'(10);
  localparam logic [CW-1:0] C_LE     = CW'(11);
  localparam logic [CW-1:0] C_GT     = CW'(12);

  typedef struct packed {
    logic o;
    logic n;
    logic c;
    logic z;
  } flags_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_RESP
  } state_e;

  flags_t          flags_q, flags_d;
  state_e          state_q, state_d;
  logic [CW-1:0]   cond_q, cond_d;
  logic            signed_q, signed_d;
  logic            taken_q, taken_d;
  logic            alu_zero;

`ifdef FLAG_SHADOW_EN
  flags_t          shadow_q, shadow_d;
`endif

  function automatic logic cond_true(input logic [CW-1:0] code,
                                     input logic          sgn,
                                     input flags_t        f);
    logic lt;
    lt = sgn ? (f.n ^ f.o) : ~f.c;
    case (code)
      C_ALWAYS: cond_true = 1'b1;
      C_Z:      cond_true = f.z;
      C_NZ:     cond_true = ~f.z;
      C_C:      cond_true = f.c;
      C_NC:     cond_true = ~f.c;
      C_N:      cond_true = f.n;
      C_NN:     cond_true = ~f.n;
      C_O:      cond_true = f.o;
      C_NO:     cond_true = ~f.o;
      C_LT:     cond_true = lt;
      C_GE:     cond_true = ~lt;
      C_LE:     cond_true = lt | f.z;
      C_GT:     cond_true = ~(lt | f.z);
      default:  cond_true = 1'b0;
    endcase
  endfunction

  assign alu_zero = (aluout == '0);

  // Flag register next state: clr_flags > restore_flags > cmpo.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    flags_d = flags_q;
`ifdef FLAG_SHADOW_EN
    shadow_d = shadow_q;
`endif
    if (clr_flags) begin
      flags_d = '{o: 1'b0, n: 1'b0, c: 1'b0, z: 1'b1};
    end
`ifdef FLAG_SHADOW_EN
    else if (restore_flags) begin
      flags_d = shadow_q;
    end
`endif
    else if (cmpo) begin
      flags_d.z = cmp_chain ? (flags_q.z & alu_zero) : alu_zero;
      flags_d.c = carryout;
      flags_d.n = aluout[WIDTH-1];
      flags_d.o = overout;
    end
`ifdef FLAG_SHADOW_EN
    // Saving the pre-edge value makes save+restore in one cycle a swap.
    if (save_flags) begin
      shadow_d = flags_q;
    end
`endif
  end

  // EVAL reads flags_q, which already holds any request-cycle cmpo update.
  always_comb begin
    state_d  = state_q;
    cond_d   = cond_q;
    signed_d = signed_q;
    taken_d  = taken_q;
    case (state_q)
      ST_IDLE: begin
        if (jmp_req) begin
          cond_d   = cond;
          signed_d = signed_in;
          state_d  = ST_EVAL;
        end
      end
      ST_EVAL: begin
        taken_d = cond_true(cond_q, signed_q, flags_q);
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (jmp_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (rst) begin
      flags_q  <= '0;
      state_q  <= ST_IDLE;
      cond_q   <= '0;
      signed_q <= 1'b0;
      taken_q  <= 1'b0;
`ifdef FLAG_SHADOW_EN
      shadow_q <= '0;
`endif
    end else begin
      flags_q  <= flags_d;
      state_q  <= state_d;
      cond_q   <= cond_d;
      signed_q <= signed_d;
      taken_q  <= taken_d;
`ifdef FLAG_SHADOW_EN
      shadow_q <= shadow_d;
`endif
    end
  end

  assign jmp_ready = (state_q == ST_IDLE);
  assign jmp_valid = (state_q == ST_RESP);
  assign jmp_taken = taken_q;
  assign flags     = flags_q;
`ifdef FLAG_SHADOW_EN
  assign shadow    = shadow_q;
`endif

endmodule

// File: tb/tb_alu_flag_unit.sv
// Self-checking bench for alu_flag_unit: directed scenarios plus random
// traffic against a transaction-level flag/jump model.
module tb_alu_flag_unit;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] aluout;
  logic             carryout, overout, cmpo, cmp_chain, clr_flags, signed_in;
  logic             jmp_req, jmp_ack;
  logic [3:0]       cond;
  logic             jmp_ready, jmp_valid, jmp_taken;
  logic [3:0]       flags;
`ifdef FLAG_SHADOW_EN
  logic             save_flags, restore_flags;
  logic [3:0]       shadow;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit       mz, mc, mn, mo;
  bit [3:0] m_shadow;
  bit       m_busy;
  int       m_age;
  bit       m_taken;

  always #5 clk = ~clk;

  alu_flag_unit #(.WIDTH(WIDTH), .NUM_CONDS(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .aluout       (aluout),
    .carryout     (carryout),
    .overout      (overout),
    .cmpo         (cmpo),
    .cmp_chain    (cmp_chain),
    .clr_flags    (clr_flags),
    .signed_in    (signed_in),
    .jmp_req      (jmp_req),
    .cond         (cond),
    .jmp_ack      (jmp_ack),
`ifdef FLAG_SHADOW_EN
    .save_flags   (save_flags),
    .restore_flags(restore_flags),
    .shadow       (shadow),
`endif
    .jmp_ready    (jmp_ready),
    .jmp_valid    (jmp_valid),
    .jmp_taken    (jmp_taken),
    .flags        (flags)
  );

  function automatic bit [3:0] m_flags();
    return {mo, mn, mc, mz};
  endfunction

  // Condition truth table written directly from the jump condition rules.
  function automatic bit m_eval(int c, bit sgn);
    bit less;
    less = sgn ? (mn != mo) : !mc;
    case (c)
      0:       return 1'b1;
      1:       return mz;
      2:       return !mz;
      3:       return mc;
      4:       return !mc;
      5:       return mn;
      6:       return !mn;
      7:       return mo;
      8:       return !mo;
      9:       return less;
      10:      return !less;
      11:      return less || mz;
      12:      return !(less || mz);
      default: return 1'b0;
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit [3:0] old;
    bit       zero;
    old  = m_flags();
    zero = (aluout == 0);
    if (rst) begin
      {mo, mn, mc, mz} = 4'b0000;
      m_shadow = 4'b0000;
      m_busy   = 1'b0;
      return;
    end
    if (clr_flags) {mo, mn, mc, mz} = 4'b0001;
`ifdef FLAG_SHADOW_EN
    else if (restore_flags) {mo, mn, mc, mz} = m_shadow;
`endif
    else if (cmpo) begin
      mz = cmp_chain ? (mz && zero) : zero;
      mc = carryout;
      mn = aluout[WIDTH-1];
      mo = overout;
    end
`ifdef FLAG_SHADOW_EN
    if (save_flags) m_shadow = old;
`endif
    // Request transaction: accepted when idle, result two edges later, held to ack.
    if (!m_busy) begin
      if (jmp_req) begin
        m_busy  = 1'b1;
        m_age   = 0;
        m_taken = m_eval(int'(cond), signed_in);
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (jmp_ack) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet_inputs();
    rst = 1'b0; aluout = '0; carryout = 1'b0; overout = 1'b0; cmpo = 1'b0;
    cmp_chain = 1'b0; clr_flags = 1'b0; signed_in = 1'b0;
    jmp_req = 1'b0; jmp_ack = 1'b0; cond = 4'd0;
`ifdef FLAG_SHADOW_EN
    save_flags = 1'b0; restore_flags = 1'b0;
`endif
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (flags !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", flags); end
    total++; if (jmp_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", jmp_ready); end
    total++; if (jmp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", jmp_valid); end
    total++; if (jmp_taken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%b want=0", jmp_taken); end
  endtask

  task automatic test_basic();
    quiet_inputs();
    cmpo = 1'b1; aluout = 8'h00; carryout = 1'b1;
    tick();
    cmpo = 1'b0;
    total++; if (flags !== 4'b0011) begin bad++; $display("FAIL basic_flags got=%b want=0011", flags); end
    jmp_req = 1'b1; cond = 4'd1;
    tick();
    jmp_req = 1'b0;
    total++; if (jmp_ready !== 1'b0 || jmp_valid !== 1'b0) begin
      bad++; $display("FAIL basic_eval ready=%b valid=%b want ready=0 valid=0", jmp_ready, jmp_valid);
    end
    tick();
    total++; if (jmp_valid !== 1'b1 || jmp_taken !== 1'b1) begin
      bad++; $display("FAIL basic_resp valid=%b taken=%b want 1 1", jmp_valid, jmp_taken);
    end
    jmp_ack = 1'b1;
    tick();
    jmp_ack = 1'b0;
    total++; if (jmp_ready !== 1'b1 || jmp_valid !== 1'b0) begin
      bad++; $display("FAIL basic_ack ready=%b valid=%b want ready=1 valid=0", jmp_ready, jmp_valid);
    end
  endtask

  task automatic test_chain();
    quiet_inputs();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    total++; if (flags !== 4'b0001) begin bad++; $display("FAIL chain_clr got=%b want=0001", flags); end
    cmpo = 1'b1; cmp_chain = 1'b1; aluout = 8'h00;
    tick();
    total++; if (flags[0] !== 1'b1) begin bad++; $display("FAIL chain_lsb_z got=%b want=1", flags[0]); end
    aluout = 8'h05;
    tick();
    cmpo = 1'b0; cmp_chain = 1'b0;
    total++; if (flags !== 4'b0000) begin bad++; $display("FAIL chain_msb got=%b want=0000", flags); end
    jmp_req = 1'b1; cond = 4'd2;
    tick();
    jmp_req = 1'b0;
    tick();
    total++; if (jmp_valid !== 1'b1 || jmp_taken !== 1'b1) begin
      bad++; $display("FAIL chain_ne valid=%b taken=%b want 1 1", jmp_valid, jmp_taken);
    end
    jmp_ack = 1'b1;
    tick();
    jmp_ack = 1'b0;
  endtask

  task automatic test_relational();
    quiet_inputs();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    // cmpo in the request cycle must be visible to the evaluation
    cmpo = 1'b1; aluout = 8'h80; overout = 1'b0; carryout = 1'b0;
    signed_in = 1'b1; jmp_req = 1'b1; cond = 4'd9;
    tick();
    cmpo = 1'b0; jmp_req = 1'b0;
    tick();
    total++; if (jmp_valid !== 1'b1 || jmp_taken !== 1'b1) begin
      bad++; $display("FAIL rel_signed_lt valid=%b taken=%b want 1 1", jmp_valid, jmp_taken);
    end
    jmp_ack = 1'b1;
    tick();
    jmp_ack = 1'b0;
    cmpo = 1'b1; aluout = 8'h80; carryout = 1'b1;
    signed_in = 1'b0; jmp_req = 1'b1; cond = 4'd9;
    tick();
    cmpo = 1'b0; jmp_req = 1'b0;
    tick();
    total++; if (jmp_valid !== 1'b1 || jmp_taken !== 1'b0) begin
      bad++; $display("FAIL rel_unsigned_lt valid=%b taken=%b want 1 0", jmp_valid, jmp_taken);
    end
    jmp_ack = 1'b1;
    tick();
    jmp_ack = 1'b0;
    signed_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    quiet_inputs();
    cmpo = 1'b1; aluout = 8'h00;
    jmp_req = 1'b1; cond = 4'd1;
    tick();
    tick();
    // Flags keep changing and a second request stays asserted while the result is held
    for (int i = 0; i < 5; i++) begin
      cmpo = 1'b1; aluout = 8'(i + 1); carryout = i[0];
      tick();
      total++; if (jmp_valid !== 1'b1 || jmp_taken !== 1'b1) begin
        bad++; $display("FAIL hold_%0d valid=%b taken=%b want 1 1", i, jmp_valid, jmp_taken);
      end
    end
    total++; if (flags[0] !== 1'b0) begin bad++; $display("FAIL hold_flag_z got=%b want=0", flags[0]); end
    cmpo = 1'b0; jmp_req = 1'b0; jmp_ack = 1'b1;
    tick();
    jmp_ack = 1'b0;
    total++; if (jmp_ready !== 1'b1 || jmp_valid !== 1'b0) begin
      bad++; $display("FAIL hold_ack ready=%b valid=%b want ready=1 valid=0", jmp_ready, jmp_valid);
    end
    tick();
    tick();
    total++; if (jmp_ready !== 1'b1 || jmp_valid !== 1'b0) begin
      bad++; $display("FAIL hold_noqueue ready=%b valid=%b want ready=1 valid=0", jmp_ready, jmp_valid);
    end
  endtask

  task automatic test_reset_mid();
    quiet_inputs();
    jmp_req = 1'b1; cond = 4'd0;
    tick();
    jmp_req = 1'b0;
    total++; if (jmp_ready !== 1'b0) begin bad++; $display("FAIL mid_eval ready=%b want=0", jmp_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (jmp_valid !== 1'b0 || jmp_ready !== 1'b1 || flags !== 4'b0000) begin
      bad++; $display("FAIL mid_reset valid=%b ready=%b flags=%b want 0 1 0000", jmp_valid, jmp_ready, flags);
    end
    tick();
    total++; if (jmp_valid !== 1'b0) begin bad++; $display("FAIL mid_dropped valid=%b want=0", jmp_valid); end
  endtask

`ifdef FLAG_SHADOW_EN
  task automatic test_shadow();
    bit [3:0] saved;
    quiet_inputs();
    cmpo = 1'b1; aluout = 8'hC0; carryout = 1'b1; overout = 1'b1;
    tick();
    cmpo = 1'b0;
    saved = 4'b1110;
    save_flags = 1'b1;
    tick();
    save_flags = 1'b0;
    total++; if (shadow !== saved) begin bad++; $display("FAIL shadow_save got=%b want=%b", shadow, saved); end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    restore_flags = 1'b1;
    tick();
    restore_flags = 1'b0;
    total++; if (flags !== saved) begin bad++; $display("FAIL shadow_restore got=%b want=%b", flags, saved); end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    save_flags = 1'b1; restore_flags = 1'b1;
    tick();
    save_flags = 1'b0; restore_flags = 1'b0;
    total++; if (flags !== saved || shadow !== 4'b0001) begin
      bad++; $display("FAIL shadow_swap flags=%b shadow=%b want %b 0001", flags, shadow, saved);
    end
  endtask
`endif

  task automatic test_random();
    quiet_inputs();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      aluout    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      carryout  = 1'($urandom);
      overout   = 1'($urandom);
      cmpo      = ($urandom_range(0, 2) != 0);
      cmp_chain = 1'($urandom);
      clr_flags = ($urandom_range(0, 9) == 0);
      signed_in = 1'($urandom);
      jmp_req   = 1'($urandom);
      jmp_ack   = ($urandom_range(0, 2) == 0);
      cond      = 4'($urandom);
`ifdef FLAG_SHADOW_EN
      save_flags    = ($urandom_range(0, 5) == 0);
      restore_flags = ($urandom_range(0, 5) == 0);
`endif
      tick();
      total++; if (flags !== m_flags()) begin
        bad++; $display("FAIL rnd_flags cyc=%0d got=%b want=%b", i, flags, m_flags());
      end
      total++; if (jmp_ready !== !m_busy) begin
        bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", i, jmp_ready, !m_busy);
      end
      total++; if (jmp_valid !== (m_busy && m_age == 1)) begin
        bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", i, jmp_valid, (m_busy && m_age == 1));
      end
      if (m_busy && m_age == 1) begin
        total++; if (jmp_taken !== m_taken) begin
          bad++; $display("FAIL rnd_taken cyc=%0d got=%b want=%b", i, jmp_taken, m_taken);
        end
      end
`ifdef FLAG_SHADOW_EN
      total++; if (shadow !== m_shadow) begin
        bad++; $display("FAIL rnd_shadow cyc=%0d got=%b want=%b", i, shadow, m_shadow);
      end
`endif
    end
    quiet_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_chain();
    test_relational();
    test_back_to_back();
    test_reset_mid();
`ifdef FLAG_SHADOW_EN
    test_shadow();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
